hc4_prog_loader: RTL and testbench

//  Writes the hc4 program ROM: it takes a framed byte stream from a host (UART RX/debug bridge),

---
 rtl/hc4_prog_loader_pkg.sv | 22 ++
 rtl/hc4_prog_loader.sv | 149 ++++++++++++++
 tb/tb_hc4_prog_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hc4_prog_loader_pkg.sv
// Shared constants and FSM encoding for the hc4 program ROM loader.
package hc4_prog_loader_pkg;

  localparam int unsigned ROM_ADDR_W = 12;
  localparam int unsigned ROM_DATA_W = 8;
  localparam int unsigned TMO_W      = 16;

  localparam logic [ROM_DATA_W-1:0] LDR_SYNC    = 8'h48;
  localparam logic [TMO_W-1:0]      LDR_TIMEOUT = 16'd50000;

  // Frame parser states, one per field of the frame.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_LEN_H  = 3'd3,
    ST_LEN_L  = 3'd4,
    ST_DATA   = 3'd5,
    ST_CHK    = 3'd6
  } ldr_state_t;

endpackage

// File: rtl/hc4_prog_loader.sv
// hc4 program ROM loader: parses framed host bytes, writes the ROM, verifies the
// checksum and holds the CPU until a load passes.
module hc4_prog_loader
  import hc4_prog_loader_pkg::*;
#(
  parameter int unsigned         ADDR_W    = ROM_ADDR_W,
  parameter int unsigned         DATA_W    = ROM_DATA_W,
  parameter logic [DATA_W-1:0]   SYNC_BYTE = LDR_SYNC,
  parameter logic [TMO_W-1:0]    TIMEOUT   = LDR_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err
);

  localparam int unsigned HI_W = ADDR_W - DATA_W;

  ldr_state_t        r_state;
  logic              r_in_ready;
  logic              r_rom_we;
  logic [ADDR_W-1:0] r_rom_waddr;
  logic [DATA_W-1:0] r_rom_wdata;
  logic              r_cpu_run;
  logic              r_busy;
  logic              r_load_ok;
  logic              r_load_err;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_sum;
  logic [TMO_W-1:0]  r_tmo;

  logic              w_acc;
  logic [DATA_W-1:0] w_chk;

  assign w_acc = in_valid && r_in_ready;
  assign w_chk = r_sum + in_data;

  // Frame FSM with pointer, remaining count, checksum and idle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_rom_we    <= 1'b0;
      r_rom_waddr <= '0;
      r_rom_wdata <= '0;
      r_cpu_run   <= 1'b0;
      r_busy      <= 1'b0;
      r_load_ok   <= 1'b0;
      r_load_err  <= 1'b0;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_sum       <= '0;
      r_tmo       <= '0;
    end else begin
      r_in_ready <= 1'b1;
      r_rom_we   <= 1'b0;
      r_load_ok  <= 1'b0;
      r_load_err <= 1'b0;

      // Idle clocks inside a frame abort the load once TIMEOUT is reached.
      if ((r_state != ST_IDLE) && !w_acc) begin
        if (r_tmo == TIMEOUT - TMO_W'(1)) begin
          r_load_err <= 1'b1;
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_tmo      <= '0;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
      end else begin
        r_tmo <= '0;
      end

      if (w_acc) begin
        case (r_state)
          ST_IDLE: begin
            if (in_data == SYNC_BYTE) begin
              r_state   <= ST_ADDR_H;
              r_cpu_run <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          ST_ADDR_H: begin
            r_ptr[ADDR_W-1:DATA_W] <= in_data[HI_W-1:0];
            r_state                <= ST_ADDR_L;
          end
          ST_ADDR_L: begin
            r_ptr[DATA_W-1:0] <= in_data;
            r_state           <= ST_LEN_H;
          end
          ST_LEN_H: begin
            r_rem[ADDR_W-1:DATA_W] <= in_data[HI_W-1:0];
            r_state                <= ST_LEN_L;
          end
          ST_LEN_L: begin
            r_rem[DATA_W-1:0] <= in_data;
            r_sum             <= '0;
            r_state           <= ST_DATA;
          end
          ST_DATA: begin
            r_rom_we    <= 1'b1;
            r_rom_waddr <= r_ptr;
            r_rom_wdata <= in_data;
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_sum       <= w_chk;
            if (r_rem == '0) begin
              r_state <= ST_CHK;
            end else begin
              r_rem <= r_rem - ADDR_W'(1);
            end
          end
          ST_CHK: begin
            if (w_chk == '0) begin
              r_load_ok <= 1'b1;
              r_cpu_run <= 1'b1;
            end else begin
              r_load_err <= 1'b1;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign rom_we    = r_rom_we;
  assign rom_waddr = r_rom_waddr;
  assign rom_wdata = r_rom_wdata;
  assign cpu_run   = r_cpu_run;
  assign busy      = r_busy;
  assign load_ok   = r_load_ok;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_hc4_prog_loader.sv
// Bench for hc4_prog_loader: frame-level reference model compared every cycle,
// plus literal checks of the write log and pulse counts.
module tb_hc4_prog_loader;

  localparam logic [15:0] TMO = 16'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, rom_we, cpu_run, busy, load_ok, load_err;
  logic [11:0] rom_waddr;
  logic [7:0]  rom_wdata;

  hc4_prog_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .cpu_run(cpu_run), .busy(busy),
    .load_ok(load_ok), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ok  = 0;
  int n_err = 0;
  logic [19:0] wlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame position counter, base address, length and running sum.
  bit          m_frame = 0;
  int          m_idx = 0, m_idle = 0, m_len = 0, m_base = 0, m_sum = 0;
  bit          e_ready = 0, e_we = 0, e_run = 0, e_busy = 0, e_ok = 0, e_err = 0;
  logic [11:0] e_waddr = '0;
  logic [7:0]  e_wdata = '0;

  always @(posedge clk) begin
    bit acc;
    int k;
    acc = in_valid && e_ready;
    if (reset) begin
      m_frame = 0; e_ready = 0; e_we = 0; e_run = 0; e_busy = 0;
      e_ok = 0; e_err = 0; e_waddr = '0; e_wdata = '0;
    end else begin
      e_we = 0; e_ok = 0; e_err = 0;
      if (!m_frame) begin
        if (acc && in_data == 8'h48) begin
          m_frame = 1; m_idx = 0; m_idle = 0; e_run = 0; e_busy = 1;
        end
      end else if (acc) begin
        m_idle = 0;
        m_idx++;
        k = m_idx - 5;
        case (m_idx)
          1: m_base = (int'(in_data) % 16) * 256;
          2: m_base = m_base + int'(in_data);
          3: m_len  = (int'(in_data) % 16) * 256;
          4: begin m_len = m_len + int'(in_data); m_sum = 0; end
          default: begin
            if (k <= m_len) begin
              e_we = 1;
              e_waddr = 12'((m_base + k) % 4096);
              e_wdata = in_data;
              m_sum = m_sum + int'(in_data);
            end else begin
              e_ok = ((m_sum + int'(in_data)) % 256) == 0;
              e_err = !e_ok;
              e_run = e_ok;
              m_frame = 0;
              e_busy = 0;
            end
          end
        endcase
      end else begin
        m_idle++;
        if (m_idle == int'(TMO)) begin
          e_err = 1; m_frame = 0; e_busy = 0;
        end
      end
      e_ready = 1;
    end
  end

  // Per-cycle comparison against the model, plus write/pulse logging.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("rom_we",   32'(rom_we),   32'(e_we));
    chk("cpu_run",  32'(cpu_run),  32'(e_run));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("load_ok",  32'(load_ok),  32'(e_ok));
    chk("load_err", 32'(load_err), 32'(e_err));
    if (e_we) begin
      chk("rom_waddr", 32'(rom_waddr), 32'(e_waddr));
      chk("rom_wdata", 32'(rom_wdata), 32'(e_wdata));
    end
    if (rom_we) wlog.push_back({rom_waddr, rom_wdata});
    if (load_ok) n_ok++;
    if (load_err) n_err++;
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_wait: got 0 expected 1 at %0t", $time);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(rom_we),    32'd0);
    chk({tag, "_waddr"}, 32'(rom_waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(rom_wdata), 32'd0);
    chk({tag, "_run"},   32'(cpu_run),   32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_ok"},    32'(load_ok),   32'd0);
    chk({tag, "_err"},   32'(load_err),  32'd0);
    chk({tag, "_ready"}, 32'(in_ready),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] fr[$];
    int ok0, err0, k;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // 1: good 3-byte load at 0x010
    wlog.delete(); ok0 = n_ok; err0 = n_err;
    fr = '{8'h48, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h9A};
    send_bytes(fr); idle(3);
    chk("t1_nwr", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("t1_w0", 32'(wlog[0]), 32'h01011);
      chk("t1_w1", 32'(wlog[1]), 32'h01122);
      chk("t1_w2", 32'(wlog[2]), 32'h01233);
    end
    chk("t1_ok", 32'(n_ok - ok0), 32'd1);
    chk("t1_run", 32'(cpu_run), 32'd1);

    // 2: bad checksum
    wlog.delete(); ok0 = n_ok; err0 = n_err;
    fr = '{8'h48, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h9B};
    send_bytes(fr); idle(3);
    chk("t2_nwr", 32'(wlog.size()), 32'd3);
    chk("t2_err", 32'(n_err - err0), 32'd1);
    chk("t2_ok", 32'(n_ok - ok0), 32'd0);
    chk("t2_run", 32'(cpu_run), 32'd0);

    // 3: address wrap FFF -> 000
    wlog.delete(); ok0 = n_ok;
    fr = '{8'h48, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'h9B};
    send_bytes(fr); idle(3);
    chk("t3_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t3_w0", 32'(wlog[0]), 32'hFFFAA);
      chk("t3_w1", 32'(wlog[1]), 32'h000BB);
    end
    chk("t3_ok", 32'(n_ok - ok0), 32'd1);

    // 4: garbage before SYNC (high nibble of ADDR_H ignored), then a good frame
    wlog.delete(); ok0 = n_ok;
    fr = '{8'h00, 8'hFF, 8'h13};
    send_bytes(fr);
    chk("t4_busy_garbage", 32'(busy), 32'd0);
    chk("t4_nwr_garbage", 32'(wlog.size()), 32'd0);
    fr = '{8'h48, 8'hF1, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA6};
    send_bytes(fr); idle(3);
    chk("t4_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("t4_w0", 32'(wlog[0]), 32'h1005A);
    chk("t4_ok", 32'(n_ok - ok0), 32'd1);

    // 5: timeout after ADDR_L
    wlog.delete(); err0 = n_err;
    fr = '{8'h48, 8'h00, 8'h10};
    send_bytes(fr);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (load_err) begin k = i; break; end
    end
    chk("t5_tmo_clks", 32'(k), 32'd16);
    chk("t5_busy", 32'(busy), 32'd0);
    idle(2);
    chk("t5_err", 32'(n_err - err0), 32'd1);
    chk("t5_run", 32'(cpu_run), 32'd0);
    chk("t5_nwr", 32'(wlog.size()), 32'd0);

    // 6: reset while DATA byte 2 of 4 is presented
    wlog.delete();
    fr = '{8'h48, 8'h02, 8'h00, 8'h00, 8'h03, 8'h01};
    send_bytes(fr);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    chk_reset_vals("rst6");
    idle(2);
    chk("t6_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("t6_w0", 32'(wlog[0]), 32'h20001);
    reset = 1'b0;
    @(negedge clk);
    wlog.delete(); ok0 = n_ok;
    fr = '{8'h48, 8'h02, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h81};
    send_bytes(fr); idle(3);
    chk("t6b_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("t6b_w0", 32'(wlog[0]), 32'h2007F);
    chk("t6b_ok", 32'(n_ok - ok0), 32'd1);
    chk("t6b_run", 32'(cpu_run), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
